uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Round-robin scheduler that shares one uart_tx transmitter among N_REQ parallel-word
//  requesters and sequences configuration writes into it between frames.
//  Sits between client logic and uart_tx: it drives i_tx_parallel/i_tx_valid/i_config
//  and tracks o_ready. One word is issued per frame; a new frame is issued only after
//  the previous one completes.
// PARAMETERS
//  N_REQ   4   number of requesters (2..8)
//  WORD_W  9   data word width; matches the uart_tx parallel bus
//  CFG_W   7   config word width; matches the uart_tx i_config layout
// PORTS
//  i_clk          in   1             system clock
//  i_rst_n        in   1             asynchronous active-low reset
//  i_req          in   N_REQ         per-requester request; hold high with data stable until granted
//  i_data         in   N_REQ*WORD_W  requester k word at [k*WORD_W +: WORD_W]
//  o_grant        out  N_REQ         one-hot, 1-cycle pulse: requester's word accepted
//  i_cfg_wr       in   1             1-cycle pulse: post a new config
//  i_cfg          in   CFG_W         config, sampled when i_cfg_wr=1 (bit0 ignored)
//  o_cfg_pending  out  1             posted config not yet applied
//  o_tx_parallel  out  WORD_W        to uart_tx i_tx_parallel
//  o_tx_valid     out  1             to uart_tx i_tx_valid
//  o_tx_config    out  CFG_W         to uart_tx i_config; bit0 = store strobe
//  i_tx_ready     in   1             from uart_tx o_ready
//  o_owner        out  $clog2(N_REQ) index of the last granted requester
//  o_busy         out  1             state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, rr pointer=N_REQ-1, and every output is 0. Any pending config is dropped.
//  All outputs are registered.
//  FSM:
//   IDLE: waits for i_tx_ready=1.
//    - If cfg pending (priority): o_tx_config <= {cfg[6:1],1}; go to CFG.
//    - Else if |i_req: choose the winner by round-robin, starting at the index after the rr pointer.
//      Register o_tx_parallel <= data[win], o_tx_valid <= 1, o_grant <= onehot(win),
//      o_owner/pointer <= win; go to ISSUE.
//   CFG:       o_tx_config[0] returns to 0 (strobe is exactly 1 cycle); clear pending; go to IDLE.
//   ISSUE:     o_tx_valid and o_grant drop (exactly 1 cycle each); go to WAIT_BUSY.
//   WAIT_BUSY: stays until i_tx_ready=0, then goes to WAIT_DONE.
//              If i_tx_ready stays 1 for 4 cycles, the frame is treated as lost: go to IDLE, no re-grant.
//   WAIT_DONE: stays until i_tx_ready=1, then goes to IDLE.
//  Latency: i_req rising in IDLE with ready=1 -> o_tx_valid and o_grant on the next cycle.
//  Requests sampled mid-frame wait; dropping i_req before grant is legal, nothing is sent.
//  Data is sampled on the decision edge only. o_tx_parallel holds its value until the next issue.
//  o_tx_valid and o_tx_config[0] are never high in the same cycle.
//  i_cfg_wr while pending: the newer value overwrites. i_cfg_wr in the same cycle as CFG clear:
//  pending stays set with the new value.
//  Fairness: with all requesters active, each requester is granted once per N_REQ frames.
// STRUCTURE
//  Package uart_pkg: FSM state localparams (one-hot); config bit positions
//  (CFG_STORE=0, CFG_WSIZE=4:1, CFG_PARITY=5, CFG_NSTOP=6); BUSY_TIMEOUT=4.
//  Sub-module rr_arbiter: N_REQ requests plus a pointer in -> one-hot winner and index out
//  (combinational).
//  Scheduler FSM, config holding register and data mux live in this module.
// TESTING
//  1. Reset mid-WAIT_DONE: assert i_rst_n=0 -> all outputs 0 immediately, state IDLE, pending config cleared.
//  2. Single requester: req[2]=1, data=9'h0A5, ready=1 -> next cycle valid=1, parallel=0A5,
//     grant=4'b0100 for 1 cycle; no second valid until ready falls and rises again.
//  3. All 4 requesting continuously -> grant order 0,1,2,3,0 across 5 frames; owner tracks it.
//  4. i_cfg_wr with cfg=7'b1010000 during a frame, req[1] also pending -> after ready returns,
//     tx_config=7'b1010001 for 1 cycle; grant[1] is issued on the later IDLE cycle.
//  5. Ready held at 1 after issue (stuck TX model) -> return to IDLE after 4 cycles;
//     the next requester is served and o_busy=0 in between.
//  6. Requester drops req[3] one cycle before ready rises -> no grant[3], no valid pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx scheduler.
// Holds the one-hot FSM state encoding, the uart_tx config word bit layout and
// the timeout after which an issued frame that never made the transmitter busy
// is abandoned.
package uart_pkg;

    // One-hot scheduler states; bit 0 is IDLE so "busy" is simply state != IDLE.
    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_CFG       = 5'b00010,
        ST_ISSUE     = 5'b00100,
        ST_WAIT_BUSY = 5'b01000,
        ST_WAIT_DONE = 5'b10000
    } state_e;

    // uart_tx config word layout.
    localparam int CFG_STORE      = 0;
    localparam int CFG_WSIZE_LSB  = 1;
    localparam int CFG_WSIZE_MSB  = 4;
    localparam int CFG_PARITY     = 5;
    localparam int CFG_NSTOP      = 6;

    // Cycles of ready=1 in WAIT_BUSY before the frame is treated as lost.
    localparam int BUSY_TIMEOUT   = 4;
    localparam int BUSY_CNT_W     = $clog2(BUSY_TIMEOUT) + 1;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches the request vector starting at the index just after ptr_i (wrapping)
// and reports the first active requester.
// Ports:
//   req_i     per-requester request
//   ptr_i     index of the most recently served requester
//   onehot_o  one-hot winner (all zero when no request)
//   idx_o     binary winner index (0 when no request)
//   valid_o   at least one request is active
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W:0] sum_s;
    logic [IDX_W:0] cand_s;

    // Walk the offsets from farthest to nearest so the nearest active request
    // after the pointer is the one left standing.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        sum_s    = '0;
        cand_s   = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            sum_s  = {1'b0, ptr_i} + (IDX_W+1)'(off);
            cand_s = (sum_s >= (IDX_W+1)'(N_REQ)) ? (sum_s - (IDX_W+1)'(N_REQ)) : sum_s;
            if (req_i[cand_s[IDX_W-1:0]]) begin
                onehot_o                     = '0;
                onehot_o[cand_s[IDX_W-1:0]]  = 1'b1;
                idx_o                        = cand_s[IDX_W-1:0];
                valid_o                      = 1'b1;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx among N_REQ word requesters, with
// posted configuration writes sequenced into the transmitter between frames.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req, i_data    requests and flat per-requester data words
//   o_grant          one-hot 1-cycle pulse when a word is accepted
//   i_cfg_wr, i_cfg  post a config word (bit 0 ignored)
//   o_cfg_pending    a posted config has not yet been applied
//   o_tx_parallel, o_tx_valid, o_tx_config   drive uart_tx
//   i_tx_ready       uart_tx o_ready
//   o_owner          last granted requester
//   o_busy           scheduler not in IDLE
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int WORD_W = 9,
    parameter  int CFG_W  = 7,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*WORD_W-1:0] i_data,
    output logic [N_REQ-1:0]        o_grant,
    input  logic                    i_cfg_wr,
    input  logic [CFG_W-1:0]        i_cfg,
    output logic                    o_cfg_pending,
    output logic [WORD_W-1:0]       o_tx_parallel,
    output logic                    o_tx_valid,
    output logic [CFG_W-1:0]        o_tx_config,
    input  logic                    i_tx_ready,
    output logic [IDX_W-1:0]        o_owner,
    output logic                    o_busy
);

    state_e                state_q, state_d;
    logic [BUSY_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [CFG_W-2:0]      cfg_q, cfg_d;
    logic                  pend_q, pend_d;
    logic [WORD_W-1:0]     par_q, par_d;
    logic                  valid_q, valid_d;
    logic [CFG_W-1:0]      cfg_out_q, cfg_out_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic                  busy_q, busy_d;

    logic [N_REQ-1:0]      win_onehot_s;
    logic [IDX_W-1:0]      win_idx_s;
    logic                  win_any_s;
    logic [WORD_W-1:0]     win_data_s;
    logic                  idle_cfg_s;
    logic                  idle_issue_s;
    logic                  cfg_lsb_unused_s;

    // The store strobe is generated here, so the posted bit 0 carries no meaning.
    assign cfg_lsb_unused_s = i_cfg[0];

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i    (i_req),
        .ptr_i    (ptr_q),
        .onehot_o (win_onehot_s),
        .idx_o    (win_idx_s),
        .valid_o  (win_any_s)
    );

    // Decision points in IDLE: a pending config always beats a data request.
    assign idle_cfg_s   = (state_q == ST_IDLE) && i_tx_ready && pend_q;
    assign idle_issue_s = (state_q == ST_IDLE) && i_tx_ready && !pend_q && win_any_s;

    // Select the winning requester's word from the flat data bus.
    always_comb begin
        win_data_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            win_data_s = win_data_s | (i_data[k*WORD_W +: WORD_W] & {WORD_W{win_onehot_s[k]}});
        end
    end

    // FSM state register and WAIT_BUSY timeout counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_cfg_s) begin
                    state_d = ST_CFG;
                end else if (idle_issue_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CFG: begin
                state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                cnt_d   = '0;
            end
            ST_WAIT_BUSY: begin
                // A transmitter that never drops ready lost the frame; give up.
                if (!i_tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == BUSY_CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + BUSY_CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (i_tx_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM output logic: next values of every registered output and the config holder.
    always_comb begin
        par_d     = par_q;
        valid_d   = 1'b0;
        grant_d   = '0;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cfg_out_d = {cfg_out_q[CFG_W-1:1], 1'b0};
        cfg_d     = i_cfg_wr ? i_cfg[CFG_W-1:1] : cfg_q;
        pend_d    = pend_q | i_cfg_wr;
        busy_d    = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (idle_cfg_s) begin
                    cfg_out_d = {cfg_q, 1'b1};
                end else if (idle_issue_s) begin
                    par_d   = win_data_s;
                    valid_d = 1'b1;
                    grant_d = win_onehot_s;
                    owner_d = win_idx_s;
                    ptr_d   = win_idx_s;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_CFG: begin
                // Stay pending if a newer value arrived after the one just applied.
                pend_d = i_cfg_wr | (cfg_q != cfg_out_q[CFG_W-1:1]);
            end
            default: begin
                pend_d = pend_q | i_cfg_wr;
            end
        endcase
    end

    // Output and config holding registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            par_q     <= '0;
            valid_q   <= 1'b0;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= IDX_W'(N_REQ - 1);
            cfg_out_q <= '0;
            cfg_q     <= '0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            par_q     <= par_d;
            valid_q   <= valid_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cfg_out_q <= cfg_out_d;
            cfg_q     <= cfg_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
        end
    end

    assign o_tx_parallel = par_q;
    assign o_tx_valid    = valid_q;
    assign o_grant       = grant_q;
    assign o_owner       = owner_q;
    assign o_tx_config   = cfg_out_q;
    assign o_cfg_pending = pend_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: a cycle table for the basic flows,
// directed sequences for reset/config/drop corner cases, and a randomized run
// against a transaction-level round-robin model with a behavioural uart_tx.
module tb_uart_tx_scheduler;

    localparam int N = 4;
    localparam int W = 9;
    localparam int C = 7;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data = '0;
    logic           cfg_wr = 1'b0;
    logic [C-1:0]   cfg = '0;
    logic           ready = 1'b0;
    logic [N-1:0]   grant;
    logic           pend;
    logic [W-1:0]   par;
    logic           valid;
    logic [C-1:0]   cfgo;
    logic [1:0]     owner;
    logic           busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.N_REQ(N), .WORD_W(W), .CFG_W(C)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_data        (data),
        .o_grant       (grant),
        .i_cfg_wr      (cfg_wr),
        .i_cfg         (cfg),
        .o_cfg_pending (pend),
        .o_tx_parallel (par),
        .o_tx_valid    (valid),
        .o_tx_config   (cfgo),
        .i_tx_ready    (ready),
        .o_owner       (owner),
        .o_busy        (busy)
    );

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       wr;
        logic [6:0] cfg;
        logic       v;
        logic [3:0] g;
        logic [8:0] par;
        logic [6:0] co;
        logic       pd;
        logic       bz;
        logic [1:0] ow;
    } vec_t;

    vec_t tbl[$];

    logic [W-1:0] wq [N][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req    = '0;
        cfg_wr = 1'b0;
        cfg    = '0;
        ready  = 1'b0;
        rst_n  = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic w, input logic [6:0] c,
                                input logic v, input logic [3:0] g, input logic [8:0] p,
                                input logic [6:0] co, input logic pd, input logic bz, input logic [1:0] ow);
        vec_t t;
        t.req = r; t.rdy = rd; t.wr = w; t.cfg = c; t.v = v; t.g = g;
        t.par = p; t.co = co; t.pd = pd; t.bz = bz; t.ow = ow;
        return t;
    endfunction

    // Round-robin choice: first active requester after 'last', wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        int res = -1;
        for (int j = N; j >= 1; j--) begin
            if (r[(last + j) % N]) res = (last + j) % N;
        end
        return res;
    endfunction

    initial begin
        logic [N-1:0] applied_req;
        logic         applied_wr;
        logic [C-1:0] applied_cfg;
        logic [5:0]   model_cfg;
        logic         ready_next;
        int           model_last, exp_idx, pre, len, cycles, drain;
        int           ord[$];
        bit           all_empty;
        int           exp_order[5];

        // Reset state
        do_reset();
        chk("reset valid",  32'(valid), 32'd0);
        chk("reset grant",  32'(grant), 32'd0);
        chk("reset par",    32'(par),   32'd0);
        chk("reset cfg",    32'(cfgo),  32'd0);
        chk("reset pend",   32'(pend),  32'd0);
        chk("reset busy",   32'(busy),  32'd0);
        chk("reset owner",  32'(owner), 32'd0);

        // Table: single requester, stuck-ready timeout, config ahead of request
        data = {9'h1F0, 9'h0A5, 9'h122, 9'h111};
        //            req      rdy   wr    cfg         v     grant    par      cfgout      pd    bz    ow
        tbl.push_back(mk(4'b0100, 1'b1, 1'b0, 7'd0,       1'b1, 4'b0100, 9'h0A5, 7'd0,       1'b0, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h0A5, 7'd0,       1'b0, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0100, 1'b0, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h0A5, 7'd0,       1'b0, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0100, 1'b0, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h0A5, 7'd0,       1'b0, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0100, 1'b1, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h0A5, 7'd0,       1'b0, 1'b0, 2'd2));
        tbl.push_back(mk(4'b0100, 1'b1, 1'b0, 7'd0,       1'b1, 4'b0100, 9'h0A5, 7'd0,       1'b0, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h0A5, 7'd0,       1'b0, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h0A5, 7'd0,       1'b0, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h0A5, 7'd0,       1'b0, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h0A5, 7'd0,       1'b0, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h0A5, 7'd0,       1'b0, 1'b0, 2'd2));
        tbl.push_back(mk(4'b1010, 1'b1, 1'b0, 7'd0,       1'b1, 4'b1000, 9'h1F0, 7'd0,       1'b0, 1'b1, 2'd3));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h1F0, 7'd0,       1'b0, 1'b1, 2'd3));
        tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h1F0, 7'd0,       1'b0, 1'b1, 2'd3));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h1F0, 7'd0,       1'b0, 1'b0, 2'd3));
        tbl.push_back(mk(4'b0001, 1'b1, 1'b0, 7'd0,       1'b1, 4'b0001, 9'h111, 7'd0,       1'b0, 1'b1, 2'd0));
        tbl.push_back(mk(4'b0010, 1'b1, 1'b1, 7'b1010000, 1'b0, 4'b0000, 9'h111, 7'd0,       1'b1, 1'b1, 2'd0));
        tbl.push_back(mk(4'b0010, 1'b0, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h111, 7'd0,       1'b1, 1'b1, 2'd0));
        tbl.push_back(mk(4'b0010, 1'b1, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h111, 7'd0,       1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(4'b0010, 1'b1, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h111, 7'b1010001, 1'b1, 1'b1, 2'd0));
        tbl.push_back(mk(4'b0010, 1'b1, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h111, 7'b1010000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(4'b0010, 1'b1, 1'b0, 7'd0,       1'b1, 4'b0010, 9'h122, 7'b1010000, 1'b0, 1'b1, 2'd1));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 7'd0,       1'b0, 4'b0000, 9'h122, 7'b1010000, 1'b0, 1'b1, 2'd1));

        for (int i = 0; i < tbl.size(); i++) begin
            req    = tbl[i].req;
            ready  = tbl[i].rdy;
            cfg_wr = tbl[i].wr;
            cfg    = tbl[i].cfg;
            step();
            chk($sformatf("row%0d valid", i), 32'(valid), 32'(tbl[i].v));
            chk($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("row%0d par",   i), 32'(par),   32'(tbl[i].par));
            chk($sformatf("row%0d cfg",   i), 32'(cfgo),  32'(tbl[i].co));
            chk($sformatf("row%0d pend",  i), 32'(pend),  32'(tbl[i].pd));
            chk($sformatf("row%0d busy",  i), 32'(busy),  32'(tbl[i].bz));
            chk($sformatf("row%0d owner", i), 32'(owner), 32'(tbl[i].ow));
        end
        cfg_wr = 1'b0;

        // Requester 3 withdraws one cycle before the frame ends: nothing is sent
        do_reset();
        req = 4'b0001; ready = 1'b1; step();
        chk("drop first grant", 32'(grant), 32'b0001);
        req = 4'b0000; ready = 1'b1; step();
        req = 4'b1000; ready = 1'b0; step();
        chk("drop in frame busy", 32'(busy), 32'd1);
        req = 4'b1000; ready = 1'b0; step();
        req = 4'b0000; ready = 1'b0; step();
        req = 4'b0000; ready = 1'b1; step();
        chk("drop idle busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drop no valid", 32'(valid), 32'd0);
            chk("drop no grant", 32'(grant), 32'd0);
        end

        // Config overwrite while pending, and a write during the CFG cycle
        do_reset();
        cfg_wr = 1'b1; cfg = 7'b0101010; ready = 1'b0; step();
        chk("cfgseq pend set", 32'(pend), 32'd1);
        cfg_wr = 1'b1; cfg = 7'b0000110; step();
        cfg_wr = 1'b0; ready = 1'b1; step();
        chk("cfgseq strobe1", 32'(cfgo), 32'(7'b0000111));
        chk("cfgseq no valid", 32'(valid), 32'd0);
        cfg_wr = 1'b1; cfg = 7'b1111000; step();
        chk("cfgseq strobe low", 32'(cfgo), 32'(7'b0000110));
        chk("cfgseq pend kept", 32'(pend), 32'd1);
        cfg_wr = 1'b0; step();
        chk("cfgseq strobe2", 32'(cfgo), 32'(7'b1111001));
        step();
        chk("cfgseq applied", 32'(cfgo), 32'(7'b1111000));
        chk("cfgseq pend clr", 32'(pend), 32'd0);

        // Asynchronous reset in the middle of WAIT_DONE with a config pending
        do_reset();
        req = 4'b0001; ready = 1'b1; step();
        req = 4'b0000; step();
        cfg_wr = 1'b1; cfg = 7'b1100110; ready = 1'b0; step();
        cfg_wr = 1'b0;
        chk("rst pre pend", 32'(pend), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst async valid", 32'(valid), 32'd0);
        chk("rst async par",   32'(par),   32'd0);
        chk("rst async pend",  32'(pend),  32'd0);
        chk("rst async busy",  32'(busy),  32'd0);
        chk("rst async cfg",   32'(cfgo),  32'd0);
        #2;
        rst_n = 1'b1;
        req = 4'b1010; ready = 1'b1; step();
        chk("rst after valid", 32'(valid), 32'd1);
        chk("rst after grant", 32'(grant), 32'b0010);
        chk("rst after cfg",   32'(cfgo),  32'd0);

        // Randomized run against a transaction-level model
        do_reset();
        for (int k = 0; k < N; k++) begin
            int n = $urandom_range(2, 7);
            for (int j = 0; j < n; j++) wq[k].push_back(W'($urandom_range(0, 511)));
        end
        model_last = N - 1;
        model_cfg  = '0;
        ready_next = 1'b1;
        pre = 0; len = 0; cycles = 0; drain = 0;
        while (drain < 30 && cycles < 3000) begin
            all_empty = 1'b1;
            applied_req = '0;
            for (int k = 0; k < N; k++) begin
                applied_req[k] = (wq[k].size() > 0);
                data[k*W +: W] = (wq[k].size() > 0) ? wq[k][0] : W'(0);
                if (wq[k].size() > 0) all_empty = 1'b0;
            end
            applied_wr  = (!all_empty) && ($urandom_range(0, 11) == 0);
            applied_cfg = C'($urandom_range(0, 127));
            req = applied_req; cfg_wr = applied_wr; cfg = applied_cfg; ready = ready_next;
            step();
            cycles++;
            if (all_empty) drain++;

            if (valid) begin
                exp_idx = rr_pick(applied_req, model_last);
                if (exp_idx < 0) begin
                    chk("rand spurious valid", 32'(valid), 32'd0);
                end else begin
                    chk("rand grant", 32'(grant), 32'(1) << exp_idx);
                    chk("rand par",   32'(par),   32'(wq[exp_idx][0]));
                    chk("rand owner", 32'(owner), 32'(exp_idx));
                    void'(wq[exp_idx].pop_front());
                    model_last = exp_idx;
                    ord.push_back(exp_idx);
                end
                chk("rand valid/strobe excl", 32'(cfgo[0]), 32'd0);
                if ($urandom_range(0, 5) == 0) begin
                    pre = 99; len = 0;
                end else begin
                    pre = $urandom_range(0, 2); len = $urandom_range(1, 5);
                end
            end else begin
                chk("rand idle grant", 32'(grant), 32'd0);
            end
            if (cfgo[0]) chk("rand cfg value", 32'(cfgo[6:1]), 32'(model_cfg));
            if (applied_wr) model_cfg = applied_cfg[6:1];

            if (pre == 99) begin
                ready_next = 1'b1;
                pre = 0;
            end else if (pre > 0) begin
                ready_next = 1'b1; pre--;
            end else if (len > 0) begin
                ready_next = 1'b0; len--;
            end else begin
                ready_next = 1'b1;
            end
        end
        if (cycles >= 3000) begin
            errors++;
            $display("FAIL rand timeout cycles=%0d limit=%0d", cycles, 3000);
        end
        chk("rand end pend", 32'(pend), 32'd0);
        chk("rand end busy", 32'(busy), 32'd0);
        chk("rand end cfg",  32'(cfgo[6:1]), 32'(model_cfg));
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fair order %0d", i), (ord.size() > i) ? 32'(ord[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
